// File: rtl/rd_tid_alloc.sv
// Read-path tID allocator: stamps AXI AR requests with sequential tIDs and returns ARIDs on retire.
// Optional protocol checking is enabled by defining RD_TID_ALLOC_ERR_CHECK_EN.

module rd_tid_alloc #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int TID_MAX    = 16,
   parameter int TID_WIDTH  = $clog2(TID_MAX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic [TID_WIDTH-1:0]  req_tid_o,
   output logic [ADDR_WIDTH-1:0] req_addr_o,
   input  logic                  retire_i,
   input  logic [TID_WIDTH-1:0]  retire_tid_i,
   output logic [ID_WIDTH-1:0]   retire_rid_o,
   output logic [TID_WIDTH:0]    outstanding_o,
   output logic                  err_o
);

   logic [TID_WIDTH:0]    outstanding_q, outstanding_d;
   logic [TID_WIDTH-1:0]  next_tid_q, next_tid_d;
   logic                  req_valid_q, req_valid_d;
   logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [ID_WIDTH-1:0]   tbl_q [TID_MAX];
   logic                  accept;
   logic                  retire_ok;

   function automatic logic [TID_WIDTH-1:0] tid_inc(input logic [TID_WIDTH-1:0] t);
      return (t == TID_WIDTH'(TID_MAX - 1)) ? '0 : t + 1'b1;
   endfunction

   // Full is judged on the registered count, so a retire frees a slot only from the next cycle.
   assign arready_o = (outstanding_q < (TID_WIDTH+1)'(TID_MAX)) && (!req_valid_q || req_ready_i);
   assign accept    = arvalid_i && arready_o;
   assign retire_ok = retire_i && (outstanding_q != '0);

   always_comb begin
      outstanding_d = outstanding_q;
      next_tid_d    = next_tid_q;
      req_valid_d   = req_valid_q;
      req_tid_d     = req_tid_q;
      req_addr_d    = req_addr_q;
      case ({accept, retire_ok})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
      if (accept) begin
         next_tid_d  = tid_inc(next_tid_q);
         req_valid_d = 1'b1;
         req_tid_d   = next_tid_q;
         req_addr_d  = araddr_i;
      end else if (req_ready_i) begin
         req_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= '0;
         next_tid_q    <= '0;
         req_valid_q   <= 1'b0;
         req_tid_q     <= '0;
         req_addr_q    <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         next_tid_q    <= next_tid_d;
         req_valid_q   <= req_valid_d;
         req_tid_q     <= req_tid_d;
         req_addr_q    <= req_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) tbl_q[next_tid_q] <= arid_i;
   end

   assign retire_rid_o  = ({1'b0, retire_tid_i} < (TID_WIDTH+1)'(TID_MAX)) ? tbl_q[retire_tid_i] : '0;
   assign req_valid_o   = req_valid_q;
   assign req_tid_o     = req_tid_q;
   assign req_addr_o    = req_addr_q;
   assign outstanding_o = outstanding_q;

`ifdef RD_TID_ALLOC_ERR_CHECK_EN
   logic [TID_WIDTH-1:0]  oldest_tid_q;
   logic                  err_q;
   logic                  ar_hold_q;
   logic [ID_WIDTH-1:0]   arid_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic                  viol;

   // A stalled AR (valid without ready) must keep valid, ARID and ARADDR stable next cycle.
   always_comb begin
      viol = (retire_i && (retire_tid_i != oldest_tid_q))
          || (retire_i && (outstanding_q == '0))
          || (ar_hold_q && (!arvalid_i || (arid_i != arid_q) || (araddr_i != araddr_q)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oldest_tid_q <= '0;
         err_q        <= 1'b0;
         ar_hold_q    <= 1'b0;
      end else begin
         if (retire_ok) oldest_tid_q <= tid_inc(oldest_tid_q);
         err_q     <= err_q | viol;
         ar_hold_q <= arvalid_i && !arready_o;
      end
   end

   always_ff @(posedge clk) begin
      arid_q   <= arid_i;
      araddr_q <= araddr_i;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rd_tid_alloc.sv
// Directed self-checking bench for rd_tid_alloc (ID_WIDTH=4, TID_MAX=16).
module tb_rd_tid_alloc;

   logic        clk = 1'b0;
   logic        rst;
   logic        arvalid_i;
   logic        arready_o;
   logic [3:0]  arid_i;
   logic [31:0] araddr_i;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [3:0]  req_tid_o;
   logic [31:0] req_addr_o;
   logic        retire_i;
   logic [3:0]  retire_tid_i;
   logic [3:0]  retire_rid_o;
   logic [4:0]  outstanding_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;
   logic [3:0] sent [16];
   int nxt, old;
   logic exp_err;

   rd_tid_alloc #(.ID_WIDTH(4), .ADDR_WIDTH(32), .TID_MAX(16), .TID_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_tid_o(req_tid_o),
      .req_addr_o(req_addr_o), .retire_i(retire_i), .retire_tid_i(retire_tid_i),
      .retire_rid_o(retire_rid_o), .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      arvalid_i = 1'b0;
      retire_i = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
`ifdef RD_TID_ALLOC_ERR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst = 1'b1; arvalid_i = 1'b0; arid_i = '0; araddr_i = '0;
      req_ready_i = 1'b1; retire_i = 1'b0; retire_tid_i = '0;
      step(); step();
      chk("rst_valid", req_valid_o, 0);
      chk("rst_tid", req_tid_o, 0);
      chk("rst_addr", req_addr_o, 0);
      chk("rst_outst", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_arready", arready_o, 1);
      rst = 1'b0;

      // Three back-to-back requests
      arvalid_i = 1'b1; arid_i = 4'd5; araddr_i = 32'h100;
      step();
      chk("b2b0_valid", req_valid_o, 1);
      chk("b2b0_tid", req_tid_o, 0);
      chk("b2b0_addr", req_addr_o, 32'h100);
      arid_i = 4'd9; araddr_i = 32'h140;
      step();
      chk("b2b1_tid", req_tid_o, 1);
      chk("b2b1_addr", req_addr_o, 32'h140);
      arid_i = 4'd2; araddr_i = 32'h180;
      step();
      chk("b2b2_tid", req_tid_o, 2);
      chk("b2b2_addr", req_addr_o, 32'h180);
      chk("b2b_outst", outstanding_o, 3);
      arvalid_i = 1'b0;
      retire_tid_i = 4'd1;
      #1 chk("b2b_rid1", retire_rid_o, 9);
      retire_tid_i = 4'd0;
      #1 chk("b2b_rid0", retire_rid_o, 5);
      step();
      chk("drain_valid", req_valid_o, 0);

      // Fill to TID_MAX, then free one slot
      do_reset();
      arvalid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         arid_i = 4'(i) ^ 4'hA; araddr_i = 32'h1000 + 32'(i * 4);
         step();
         chk("fill_tid", req_tid_o, i);
      end
      chk("full_outst", outstanding_o, 16);
      arid_i = 4'hE; araddr_i = 32'h2000;
      #1 chk("full_arready", arready_o, 0);
      retire_i = 1'b1; retire_tid_i = 4'd0;
      #1 chk("full_rid0", retire_rid_o, 4'hA);
      chk("full_retire_arready", arready_o, 0);
      step();
      retire_i = 1'b0;
      chk("freed_outst", outstanding_o, 15);
      chk("freed_arready", arready_o, 1);
      step();
      arvalid_i = 1'b0;
      chk("ar17_tid", req_tid_o, 0);
      chk("ar17_addr", req_addr_o, 32'h2000);
      chk("ar17_outst", outstanding_o, 16);
      retire_tid_i = 4'd0;
      #1 chk("ar17_rid", retire_rid_o, 4'hE);

      // Backpressure
      do_reset();
      req_ready_i = 1'b0;
      arvalid_i = 1'b1; arid_i = 4'd3; araddr_i = 32'h300;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", req_valid_o, 1);
         chk("bp_tid", req_tid_o, 0);
         chk("bp_addr", req_addr_o, 32'h300);
         chk("bp_outst", outstanding_o, 1);
         chk("bp_arready", arready_o, 0);
         if (i < 3) step();
      end
      req_ready_i = 1'b1;
      #1 chk("bp_release_arready", arready_o, 1);
      step();
      arvalid_i = 1'b0;
      chk("bp_second_tid", req_tid_o, 1);
      chk("bp_second_outst", outstanding_o, 2);

      // Wrap with simultaneous accept and retire every cycle
      do_reset();
      arvalid_i = 1'b1;
      nxt = 0; old = 0;
      for (int i = 0; i < 4; i++) begin
         arid_i = 4'((nxt * 7 + 3) & 15); araddr_i = 32'h4000 + 32'(nxt);
         step();
         sent[nxt] = arid_i;
         nxt = (nxt + 1) % 16;
      end
      for (int n = 0; n < 40; n++) begin
         arid_i = 4'(($urandom_range(0, 15) + n) & 15); araddr_i = 32'h5000 + 32'(n);
         retire_i = 1'b1; retire_tid_i = 4'(old);
         #1 chk("wrap_rid", retire_rid_o, sent[old]);
         step();
         chk("wrap_tid", req_tid_o, nxt);
         chk("wrap_outst", outstanding_o, 4);
         sent[nxt] = arid_i;
         nxt = (nxt + 1) % 16;
         old = (old + 1) % 16;
      end
      arvalid_i = 1'b0; retire_i = 1'b0;

      // Out-of-order retire
      do_reset();
      arvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         arid_i = 4'(i); araddr_i = 32'h600 + 32'(i);
         step();
      end
      arvalid_i = 1'b0;
      retire_i = 1'b1; retire_tid_i = 4'd0;
      step();
      retire_tid_i = 4'd1;
      step();
      chk("err_before", err_o, 0);
      retire_tid_i = 4'd3;
      step();
      retire_i = 1'b0;
      chk("err_set", err_o, exp_err);
      step(); step();
      chk("err_sticky", err_o, exp_err);

      // Asynchronous reset with 5 outstanding
      arvalid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         arid_i = 4'(i + 8); araddr_i = 32'h700 + 32'(i);
         step();
      end
      arvalid_i = 1'b0;
      chk("pre_rst_outst", outstanding_o, 5);
      chk("pre_rst_valid", req_valid_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", req_valid_o, 0);
      chk("arst_tid", req_tid_o, 0);
      chk("arst_addr", req_addr_o, 0);
      chk("arst_outst", outstanding_o, 0);
      chk("arst_err", err_o, 0);
      step();
      rst = 1'b0;
      arvalid_i = 1'b1; arid_i = 4'd1; araddr_i = 32'h800;
      step();
      arvalid_i = 1'b0;
      chk("post_rst_tid", req_tid_o, 0);
      chk("post_rst_addr", req_addr_o, 32'h800);
      chk("post_rst_outst", outstanding_o, 1);
      retire_tid_i = 4'd0;
      #1 chk("post_rst_rid", retire_rid_o, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
